zx_video_fetch: RTL and testbench

- Parametrised ZX Spectrum ULA video pixel/attribute fetch and colour pipeline.
- Fetches bitmap and attribute bytes from an external fixed-latency video RAM port using a per-cell fetch sequencer.
- Serialises pixels with integer pixel replication and applies flash and bright in the attribute colour mapping.
- Sits between the raster timing generator (x, y, de, screen, frame_start) and the VGA DAC pins; also generates the frame IRQ.

---
 rtl/zx_video_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_zx_video_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/zx_video_fetch.sv
// ZX Spectrum ULA video fetch: per-cell bitmap/attribute reads, pixel serialiser, colour map, frame IRQ.
// Latency: colour for input coordinate x appears on VGA_* C+1 clocks later (C = 8*SCALE).
// Backpressure: none; the video RAM port is fixed-latency and always accepts a read strobe.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   x, y, de, screen      raster position, display enable, inside-paper flag
//   frame_start           one-clock pulse at the first clock of a frame
//   border                border colour {G,R,B}
//   vaddr, vrd, vdata     video RAM byte address / read strobe / data (RAM_LAT clocks after vrd)
//   hicolor               Timex 8x1 attribute mode (only with ZXV_HICOLOR_EN defined)
//   VGA_R, VGA_G, VGA_B   colour channels, OUT_BITS each
//   irq                   frame interrupt, IRQ_LEN clocks wide
// Optional feature macro: ZXV_HICOLOR_EN (bank-1 per-row attributes when hicolor=1).

module zx_video_fetch #(
  parameter int SCALE        = 2,
  parameter int OUT_BITS     = 3,
  parameter int RAM_LAT      = 1,
  parameter int FLASH_FRAMES = 16,
  parameter int IRQ_LEN      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  input  logic                de,
  input  logic                screen,
  input  logic                frame_start,
  input  logic [2:0]          border,
  output logic [13:0]         vaddr,
  output logic                vrd,
  input  logic [7:0]          vdata,
  input  logic                hicolor,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                irq
);

  localparam int LS = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam int C  = 8 * SCALE;
  localparam int PW = LS + 3;
  localparam int IW = $clog2(IRQ_LEN + 1) + 1;

  localparam logic [PW-1:0] P_PIX_LAT  = PW'(RAM_LAT);
  localparam logic [PW-1:0] P_ATTR_REQ = PW'(RAM_LAT + 1);
  localparam logic [PW-1:0] P_ATTR_LAT = PW'(2 * RAM_LAT + 1);
  localparam logic [PW-1:0] P_LAST     = PW'(C - 1);
  localparam logic [PW-1:0] SUB_MASK   = PW'(SCALE - 1);

  logic [10:0]   xs, ys;
  logic [PW-1:0] p;
  logic [13:0]   bm_addr, at_addr;
  logic          pix_req, attr_req;

  logic          pix_pend, attr_pend;
  logic [7:0]    tmp_pix, tmp_attr;
  logic [7:0]    pix_sr, attr_cur;
  logic [C-1:0]  de_dl, scr_dl;
  logic [7:0]    fcnt;
  logic          flash_ph;
  logic [IW-1:0] irq_cnt;

  logic          use_ink;
  logic [2:0]    cur_grb;
  logic [OUT_BITS-1:0] nxt_r, nxt_g, nxt_b;

  assign xs = x >> LS;
  assign ys = y >> LS;
  assign p  = x[PW-1:0];

  // Only bits [7:0] of the scaled coordinates address the 256x192 screen.
  logic unused_bits;
  assign unused_bits = &{1'b0, xs, ys, hicolor};

  assign bm_addr = {1'b0, ys[7:6], ys[2:0], ys[5:3], xs[7:3]};

`ifdef ZXV_HICOLOR_EN
  assign at_addr = hicolor ? {1'b1, ys[7:6], ys[2:0], ys[5:3], xs[7:3]}
                           : {1'b0, 3'b110, ys[7:3], xs[7:3]};
`else
  assign at_addr = {1'b0, 3'b110, ys[7:3], xs[7:3]};
`endif

  function automatic logic [OUT_BITS-1:0] level(input logic on, input logic bright);
    logic [OUT_BITS-1:0] l;
    l = '0;
    l[OUT_BITS-1] = on;
    l[OUT_BITS-2] = on & bright;
    return l;
  endfunction

  // Read strobes come straight from the phase so vdata lines up with p==RAM_LAT
  // and p==2*RAM_LAT+1; reset gates them off immediately.
  always_comb begin
    vrd      = 1'b0;
    vaddr    = '0;
    pix_req  = 1'b0;
    attr_req = 1'b0;
    if (!reset && de) begin
      if (p == '0) begin
        vrd     = 1'b1;
        pix_req = 1'b1;
        vaddr   = bm_addr;
      end else if (p == P_ATTR_REQ) begin
        vrd      = 1'b1;
        attr_req = 1'b1;
        vaddr    = at_addr;
      end
    end
  end

  always_comb begin
    nxt_r   = '0;
    nxt_g   = '0;
    nxt_b   = '0;
    use_ink = pix_sr[7] ^ (attr_cur[7] & flash_ph);
    cur_grb = use_ink ? attr_cur[2:0] : attr_cur[5:3];
    if (de_dl[C-1]) begin
      if (scr_dl[C-1]) begin
        nxt_g = level(cur_grb[2], attr_cur[6]);
        nxt_r = level(cur_grb[1], attr_cur[6]);
        nxt_b = level(cur_grb[0], attr_cur[6]);
      end else begin
        nxt_g = level(border[2], 1'b1);
        nxt_r = level(border[1], 1'b1);
        nxt_b = level(border[0], 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_pend  <= 1'b0;
      attr_pend <= 1'b0;
      tmp_pix   <= '0;
      tmp_attr  <= '0;
      pix_sr    <= '0;
      attr_cur  <= '0;
      de_dl     <= '0;
      scr_dl    <= '0;
      fcnt      <= '0;
      flash_ph  <= 1'b0;
      irq_cnt   <= '0;
      irq       <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      // Pending flags ensure only data for a request issued since reset is captured.
      if (pix_req) begin
        pix_pend <= 1'b1;
      end else if (p == P_PIX_LAT && pix_pend) begin
        tmp_pix  <= vdata;
        pix_pend <= 1'b0;
      end

      if (attr_req) begin
        attr_pend <= 1'b1;
      end else if (p == P_ATTR_LAT && attr_pend) begin
        tmp_attr  <= vdata;
        attr_pend <= 1'b0;
      end

      // The shifter runs from x alone so a de drop still drains the loaded cell.
      if (p == P_LAST) begin
        pix_sr   <= tmp_pix;
        attr_cur <= tmp_attr;
      end else if ((p & SUB_MASK) == SUB_MASK) begin
        pix_sr <= {pix_sr[6:0], 1'b0};
      end

      de_dl  <= {de_dl[C-2:0], de};
      scr_dl <= {scr_dl[C-2:0], screen};

      if (frame_start) begin
        if (fcnt == 8'(FLASH_FRAMES - 1)) begin
          fcnt     <= '0;
          flash_ph <= ~flash_ph;
        end else begin
          fcnt <= fcnt + 8'(1);
        end
      end

      // irq stays high while the remaining count before this clock exceeds 1.
      if (frame_start) begin
        irq_cnt <= IW'(IRQ_LEN);
        irq     <= 1'b1;
      end else begin
        if (irq_cnt != '0) irq_cnt <= irq_cnt - IW'(1);
        irq <= |irq_cnt[IW-1:1];
      end

      VGA_R <= nxt_r;
      VGA_G <= nxt_g;
      VGA_B <= nxt_b;
    end
  end

endmodule

// File: tb/tb_zx_video_fetch.sv
// Randomised bench for zx_video_fetch: raster stimulus, fixed-latency RAM model, reference colour model.
// Expected colour for an output clock is derived from the raster history C+1 clocks earlier.
// No backpressure; the bench RAM answers every read after exactly RAM_LAT clocks.

module tb_zx_video_fetch;

  localparam int SCALE        = 2;
  localparam int OUT_BITS     = 3;
  localparam int RAM_LAT      = 1;
  localparam int FLASH_FRAMES = 16;
  localparam int IRQ_LEN      = 32;
  localparam int LS           = 1;
  localparam int C            = 8 * SCALE;
  localparam int LINE_W       = 256 * SCALE + 64;
  localparam int DE_W         = 256 * SCALE + 32;
  localparam int N_LINES      = 12;
  localparam int N_CYC        = 8192;

`ifdef ZXV_HICOLOR_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [10:0]         x, y;
  logic                de, screen, frame_start;
  logic [2:0]          border;
  logic [13:0]         vaddr;
  logic                vrd;
  logic [7:0]          vdata;
  logic                hicolor;
  logic [OUT_BITS-1:0] VGA_R, VGA_G, VGA_B;
  logic                irq;

  zx_video_fetch #(
    .SCALE(SCALE), .OUT_BITS(OUT_BITS), .RAM_LAT(RAM_LAT),
    .FLASH_FRAMES(FLASH_FRAMES), .IRQ_LEN(IRQ_LEN)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .de(de), .screen(screen),
    .frame_start(frame_start), .border(border), .vaddr(vaddr), .vrd(vrd),
    .vdata(vdata), .hicolor(hicolor), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16384];

  int  h_x [N_CYC];
  int  h_y [N_CYC];
  bit  h_de [N_CYC];
  bit  h_scr [N_CYC];
  bit  h_rst [N_CYC];
  bit  h_hc [N_CYC];
  int  h_brd [N_CYC];
  int  h_nfs [N_CYC];
  int  h_lfs [N_CYC];
  int  h_req [N_CYC];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nfs   = 0;
  int lfs   = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lvl(input int on, input int br);
    return (on != 0) ? ((br != 0 ? 3 : 2) << (OUT_BITS - 2)) : 0;
  endfunction

  function automatic int ref_bm(input int xx, input int yy);
    int xq, yq;
    xq = xx >> LS;
    yq = yy >> LS;
    return (((yq >> 6) & 3) << 11) | ((yq & 7) << 8) | (((yq >> 3) & 7) << 5) | ((xq >> 3) & 31);
  endfunction

  function automatic int ref_at(input int xx, input int yy, input bit hc);
    if (HC_EN && hc) return 'h2000 | ref_bm(xx, yy);
    return 'h1800 + (((yy >> LS) >> 3) * 32) + (((xx >> LS) >> 3) & 31);
  endfunction

  function automatic bit any_rst(input int a, input int b);
    for (int i = a; i <= b; i++) if (h_rst[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Outputs seen in cycle k were captured at the end of cycle k-1 from the
  // raster position presented C clocks before that.
  task automatic check_outputs(input int k);
    int cap, src, cs, er, eg, eb, col, fl, pix, atb, dot, ink, br, xq;
    bit skip;
    cap = k - 1;
    src = cap - C;
    er = 0; eg = 0; eb = 0; skip = 1'b0;
    if (!h_rst[cap] && src >= 0 && !any_rst(src, cap) && h_de[src]) begin
      if (!h_scr[src]) begin
        eg = lvl((h_brd[cap] >> 2) & 1, 1);
        er = lvl((h_brd[cap] >> 1) & 1, 1);
        eb = lvl(h_brd[cap] & 1, 1);
      end else begin
        cs = src - (h_x[src] % C);
        if (cs < 0 || any_rst(cs, src)) begin
          skip = 1'b1;
        end else begin
          fl  = (h_nfs[cap] / FLASH_FRAMES) % 2;
          xq  = h_x[src] >> LS;
          pix = int'(mem[ref_bm(h_x[src], h_y[src])]);
          atb = int'(mem[ref_at(h_x[src], h_y[src], h_hc[src])]);
          dot = (pix >> (7 - (xq & 7))) & 1;
          ink = dot ^ (((atb >> 7) & 1) & fl);
          col = (ink != 0) ? (atb & 7) : ((atb >> 3) & 7);
          br  = (atb >> 6) & 1;
          eg  = lvl((col >> 2) & 1, br);
          er  = lvl((col >> 1) & 1, br);
          eb  = lvl(col & 1, br);
        end
      end
    end
    if (!skip) begin
      check_val("vga_r", 32'(VGA_R), er);
      check_val("vga_g", 32'(VGA_G), eg);
      check_val("vga_b", 32'(VGA_B), eb);
    end
    check_val("irq", 32'(irq), (h_lfs[cap] >= 0 && (k - h_lfs[cap]) <= IRQ_LEN) ? 1 : 0);
  endtask

  task automatic drive_cycle(input bit r, input int xx, input int yy, input bit d,
                             input bit s, input bit f, input int b, input bit hc);
    int  pp, ea;
    bit  ev;
    if (cyc >= 1) check_outputs(cyc);
    reset       = r;
    x           = 11'(xx);
    y           = 11'(yy);
    de          = d;
    screen      = s;
    frame_start = f;
    border      = 3'(b);
    hicolor     = hc;
    if (cyc >= RAM_LAT && h_req[cyc - RAM_LAT] >= 0) vdata = mem[h_req[cyc - RAM_LAT]];
    else vdata = 8'($urandom);
    h_x[cyc] = xx; h_y[cyc] = yy; h_de[cyc] = d; h_scr[cyc] = s;
    h_rst[cyc] = r; h_hc[cyc] = hc; h_brd[cyc] = b; h_nfs[cyc] = nfs;
    if (r) begin
      nfs = 0;
      lfs = -1;
    end else if (f) begin
      nfs++;
      lfs = cyc;
    end
    h_lfs[cyc] = lfs;
    #3;
    pp = xx % C;
    ev = !r && d && (pp == 0 || pp == RAM_LAT + 1);
    check_val("vrd", 32'(vrd), ev ? 1 : 0);
    if (ev) begin
      ea = (pp == 0) ? ref_bm(xx, yy) : ref_at(xx, yy, hc);
      check_val((pp == 0) ? "vaddr_bm" : "vaddr_attr", 32'(vaddr), ea);
    end
    h_req[cyc] = vrd ? int'(vaddr) : -1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  yy, brd, rst_at;
    bit  hc, r, fs;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    mem[0]      = 8'hA5;
    mem['h1800] = 8'h07;
    reset = 1'b1; x = '0; y = '0; de = 1'b0; screen = 1'b0;
    frame_start = 1'b0; border = '0; hicolor = 1'b0; vdata = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int l = 0; l < N_LINES; l++) begin
      if (l == 0)      yy = 0;
      else if (l == 1) yy = 130;
      else if (l == 5) yy = 400;
      else             yy = $urandom_range(0, 192 * SCALE - 1);
      brd    = (l == 5) ? 2 : $urandom_range(0, 7);
      hc     = (l == 0 || l == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      rst_at = (l == 7) ? (C * $urandom_range(2, 30) + $urandom_range(3, 12)) : -1;
      for (int xx = 0; xx < LINE_W; xx++) begin
        r  = (rst_at >= 0 && xx >= rst_at && xx < rst_at + 3);
        fs = (l == 0 && xx == 5) || ($urandom_range(0, 47) == 0);
        drive_cycle(r, xx, yy, xx < DE_W, (xx < 256 * SCALE) && (yy < 192 * SCALE),
                    fs, brd, hc);
      end
    end
    for (int xx = 0; xx < C + 4; xx++) drive_cycle(1'b0, xx, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_outputs(cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
